mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// - Shares the single memory port of the multicycle core between two requesters:
//   requester 0 (CPU memory interface, fetch/load/store) and requester 1 (DMA/debug master).
// - Sequences each access over a fixed MEM_LAT-cycle memory window, returns read data and
//   pulses a one-cycle acknowledge. Sits between Control_MULTI/datapath and the memory block.
// PARAMETERS
// - ADDR_W   32  address width
// - DATA_W   32  data width
// - MEM_LAT   2  cycles memory enables are held per access (>=1); read data sampled on last cycle
// PORTS
// - iCLK        in   1       clock, rising edge
// - iRST        in   1       reset, asynchronous, active-high
// - iReq0/iReq1 in   1       access request; hold with attributes stable until oAck
// - iWe0/iWe1   in   1       1=write, 0=read
// - iAddr0/1    in   ADDR_W  address
// - iWData0/1   in   DATA_W  write data
// - oGnt0/oGnt1 out  1       high while requester owns the port (ACCESS and DONE)
// - oAck0/oAck1 out  1       one-cycle completion pulse
// - oRData0/1   out  DATA_W  read data, valid from oAck, held until that requester's next read completes
// - oMemAddr    out  ADDR_W  memory address
// - oMemWData   out  DATA_W  memory write data
// - oMemWe      out  1       memory write enable
// - oMemRe      out  1       memory read enable
// - iMemRData   in   DATA_W  memory read data
// BEHAVIOUR
// - Reset: state=IDLE; every output 0; oRData0/1=0; count=0; RR pointer=1 (req 0 wins first tie).
// - IDLE: if any iReq high, select winner, latch addr/wdata/we into registers,
//   count=MEM_LAT-1, go ACCESS. Else stay in IDLE.
// - ACCESS: oGnt(winner)=1; oMemAddr/oMemWData driven from latched regs;
//   oMemRe=~we, oMemWe=we, for exactly MEM_LAT cycles. When count==0: reads capture
//   iMemRData into winner's oRData; go DONE. Else count decrements.
// - DONE: oAck(winner)=1 for one cycle; oGnt stays high; mem enables 0; go IDLE.
// - Latency: request sampled at edge N -> ACCESS cycles N+1..N+MEM_LAT, oAck in cycle N+MEM_LAT+1.
//   Minimum back-to-back period MEM_LAT+2 cycles.
// - Request still high in IDLE after oAck is treated as a new transaction.
// - Request dropped mid-transaction: access still completes and oAck is still pulsed.
// - Input changes after acceptance are ignored (latched copies drive memory).
// - Only one oGnt and at most one oAck high at any time. Mem enables 0 outside ACCESS.
// - oMemAddr/oMemWData=0 outside ACCESS.
// - iRST mid-ACCESS/DONE: immediate return to reset values; no oAck is issued for the aborted access.
// - Counter width $clog2(MEM_LAT+1); MEM_LAT=1 gives a single-cycle ACCESS.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined: on a tie in IDLE, grant goes to the requester not served last.
//   Pointer updates on every grant.
// - ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins a tie.
//   Requester 1 may starve. Pointer logic is absent.
// TESTING
// - MEM_LAT=2, iReq0 read addr 0x40, mem returns 0xDEADBEEF:
//   oMemRe high 2 cycles, oAck0 at cycle 3, oRData0=0xDEADBEEF.
// - iReq1 write addr 0x10 data 0x12345678:
//   oMemWe high exactly 2 cycles, addr/data stable, oMemRe=0, oAck1 pulse 1 cycle.
// - iReq0 and iReq1 held high together, RR enabled: grants 0,1,0,1.
//   RR disabled: grants 0,0,0; oGnt1 never high.
// - iReq0 dropped and iAddr0 changed during ACCESS:
//   memory sees original address, oAck0 still pulses.
// - iRST asserted in 2nd ACCESS cycle: all outputs 0 before next edge, no oAck.
//   Fresh iReq1 after release completes normally in MEM_LAT+1 cycles.
// - MEM_LAT=1, iReq0 read: oMemRe high 1 cycle, oAck0 at cycle 2.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single multicycle memory port between the CPU (requester 0)
// and a DMA/debug master (requester 1). Each access holds the memory enables for MEM_LAT
// cycles, then pulses a one-cycle acknowledge to the winner.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise requester 0
// always wins a tie.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iReq0,
    input  logic              iReq1,
    input  logic              iWe0,
    input  logic              iWe1,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [DATA_W-1:0] iWData0,
    input  logic [DATA_W-1:0] iWData1,
    output logic              oGnt0,
    output logic              oGnt1,
    output logic              oAck0,
    output logic              oAck1,
    output logic [DATA_W-1:0] oRData0,
    output logic [DATA_W-1:0] oRData1,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    output logic              oMemWe,
    output logic              oMemRe,
    input  logic [DATA_W-1:0] iMemRData
);

    localparam int unsigned   CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             winner;
    logic             pick;
    logic             tieWinner;

`ifdef ARB_ROUND_ROBIN_EN
    // Requester served by the most recent grant; reset to 1 so requester 0 wins the first tie.
    logic lastServed;
    assign tieWinner = ~lastServed;
`else
    assign tieWinner = 1'b0;
`endif

    // Winner selection for a grant issued from IDLE.
    always_comb begin
        pick = 1'b0;
        if (iReq0 && iReq1) begin
            pick = tieWinner;
        end else begin
            pick = iReq1;
        end
    end

    // Arbiter FSM; the memory-side output registers double as the latched request copy.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= StIdle;
            count     <= '0;
            winner    <= 1'b0;
            oGnt0     <= 1'b0;
            oGnt1     <= 1'b0;
            oAck0     <= 1'b0;
            oAck1     <= 1'b0;
            oRData0   <= '0;
            oRData1   <= '0;
            oMemAddr  <= '0;
            oMemWData <= '0;
            oMemWe    <= 1'b0;
            oMemRe    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            lastServed <= 1'b1;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (iReq0 || iReq1) begin
                        winner    <= pick;
                        oGnt0     <= ~pick;
                        oGnt1     <= pick;
                        oMemAddr  <= pick ? iAddr1 : iAddr0;
                        oMemWData <= pick ? iWData1 : iWData0;
                        oMemWe    <= pick ? iWe1 : iWe0;
                        oMemRe    <= pick ? ~iWe1 : ~iWe0;
                        count     <= CNT_INIT;
                        state     <= StAccess;
`ifdef ARB_ROUND_ROBIN_EN
                        lastServed <= pick;
`endif
                    end
                end
                StAccess: begin
                    if (count == '0) begin
                        // Read data is sampled on the last cycle of the memory window.
                        if (oMemRe) begin
                            if (winner) begin
                                oRData1 <= iMemRData;
                            end else begin
                                oRData0 <= iMemRData;
                            end
                        end
                        oMemAddr  <= '0;
                        oMemWData <= '0;
                        oMemWe    <= 1'b0;
                        oMemRe    <= 1'b0;
                        oAck0     <= ~winner;
                        oAck1     <= winner;
                        state     <= StDone;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                StDone: begin
                    oAck0 <= 1'b0;
                    oAck1 <= 1'b0;
                    oGnt0 <= 1'b0;
                    oGnt1 <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vectors for the two-requester memory arbiter, with a
// MEM_LAT=2 instance for most sequences and a MEM_LAT=1 instance for the short window.
module tb_mem_bus_arbiter;

    localparam int unsigned LAT = 2;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        iCLK;
    logic        iRST;
    logic        iReq0, iReq1, iWe0, iWe1;
    logic [31:0] iAddr0, iAddr1, iWData0, iWData1, iMemRData;

    logic        oGnt0, oGnt1, oAck0, oAck1, oMemWe, oMemRe;
    logic [31:0] oRData0, oRData1, oMemAddr, oMemWData;

    logic        oGnt0L1, oGnt1L1, oAck0L1, oAck1L1, oMemWeL1, oMemReL1;
    logic [31:0] oRData0L1, oRData1L1, oMemAddrL1, oMemWDataL1;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iReq0(iReq0), .iReq1(iReq1), .iWe0(iWe0), .iWe1(iWe1),
        .iAddr0(iAddr0), .iAddr1(iAddr1), .iWData0(iWData0), .iWData1(iWData1),
        .oGnt0(oGnt0), .oGnt1(oGnt1), .oAck0(oAck0), .oAck1(oAck1),
        .oRData0(oRData0), .oRData1(oRData1), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
        .oMemWe(oMemWe), .oMemRe(oMemRe), .iMemRData(iMemRData)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dutL1 (
        .iCLK(iCLK), .iRST(iRST),
        .iReq0(iReq0), .iReq1(iReq1), .iWe0(iWe0), .iWe1(iWe1),
        .iAddr0(iAddr0), .iAddr1(iAddr1), .iWData0(iWData0), .iWData1(iWData1),
        .oGnt0(oGnt0L1), .oGnt1(oGnt1L1), .oAck0(oAck0L1), .oAck1(oAck1L1),
        .oRData0(oRData0L1), .oRData1(oRData1L1), .oMemAddr(oMemAddrL1),
        .oMemWData(oMemWDataL1), .oMemWe(oMemWeL1), .oMemRe(oMemReL1), .iMemRData(iMemRData)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        req0;
        logic        req1;
        logic        we0;
        logic        we1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [31:0] mem;
        logic        expWin;
        logic        expWe;
        logic [31:0] expAddr;
        logic [31:0] expWData;
    } vec_t;

    vec_t        vecs[6];
    int          nChecks = 0;
    int          nErrors = 0;
    logic [31:0] mR0, mR1;

    task automatic chk1(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge with both instances in IDLE; returns at a negedge in IDLE.
    task automatic resetDut();
        iRST = 1'b1;
        iReq0 = 1'b0;
        iReq1 = 1'b0;
        @(negedge iCLK);
        iRST = 1'b0;
        mR0 = '0;
        mR1 = '0;
    endtask

    // One complete transaction from IDLE on the MEM_LAT=2 instance.
    task automatic runTxn(input vec_t v, input string tag);
        iReq0 = v.req0;   iReq1 = v.req1;
        iWe0 = v.we0;     iWe1 = v.we1;
        iAddr0 = v.addr0; iAddr1 = v.addr1;
        iWData0 = v.wd0;  iWData1 = v.wd1;
        iMemRData = v.mem;
        @(posedge iCLK);
        for (int k = 0; k < int'(LAT); k++) begin
            @(negedge iCLK);
            chk1({tag, " access gnt0"}, oGnt0, !v.expWin);
            chk1({tag, " access gnt1"}, oGnt1, v.expWin);
            chk1({tag, " access re"}, oMemRe, !v.expWe);
            chk1({tag, " access we"}, oMemWe, v.expWe);
            chk32({tag, " access addr"}, oMemAddr, v.expAddr);
            chk32({tag, " access wdata"}, oMemWData, v.expWData);
            chk1({tag, " access ack0"}, oAck0, 1'b0);
            chk1({tag, " access ack1"}, oAck1, 1'b0);
        end
        @(negedge iCLK);
        if (!v.expWe) begin
            if (v.expWin) mR1 = v.mem;
            else          mR0 = v.mem;
        end
        chk1({tag, " done ack0"}, oAck0, !v.expWin);
        chk1({tag, " done ack1"}, oAck1, v.expWin);
        chk1({tag, " done gnt0"}, oGnt0, !v.expWin);
        chk1({tag, " done gnt1"}, oGnt1, v.expWin);
        chk1({tag, " done re"}, oMemRe, 1'b0);
        chk1({tag, " done we"}, oMemWe, 1'b0);
        chk32({tag, " done addr"}, oMemAddr, 32'h0);
        chk32({tag, " rdata0"}, oRData0, mR0);
        chk32({tag, " rdata1"}, oRData1, mR1);
        iReq0 = 1'b0;
        iReq1 = 1'b0;
        @(negedge iCLK);
        chk1({tag, " idle ack0"}, oAck0, 1'b0);
        chk1({tag, " idle ack1"}, oAck1, 1'b0);
        chk1({tag, " idle gnt0"}, oGnt0, 1'b0);
        chk1({tag, " idle gnt1"}, oGnt1, 1'b0);
    endtask

    initial begin
        int   nAck;
        int   gnt1Cycles;
        int   overlap;
        int   ackAt[4];
        logic ackWho[4];
        vec_t v;

        // First vector is a tie straight after reset: requester 0 wins in either build.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h10, 32'h0, 32'h12345678,
                    32'hDEADBEEF, 1'b0, 1'b0, 32'h40, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 32'h10, 32'h0000AAAA, 32'h12345678,
                    32'hFFFFFFFF, 1'b1, 1'b1, 32'h10, 32'h12345678};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h84, 32'h80, 32'h11111111, 32'h0,
                    32'hCAFEF00D, 1'b1, 1'b0, 32'h80, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h48, 32'hA5A5A5A5, 32'h5A5A5A5A,
                    32'h0, 1'b0, 1'b1, 32'h44, 32'hA5A5A5A5};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h4, 32'h0, 32'h22222222,
                    32'h0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'hFFFFFFFF, 32'h33333333, 32'h44444444,
                    32'h80000001, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h44444444};

        iRST = 1'b1;
        iReq0 = 1'b0; iReq1 = 1'b0; iWe0 = 1'b0; iWe1 = 1'b0;
        iAddr0 = '0; iAddr1 = '0; iWData0 = '0; iWData1 = '0; iMemRData = '0;
        mR0 = '0; mR1 = '0;
        repeat (2) @(negedge iCLK);

        // Reset state of both instances.
        chk1("reset gnt0", oGnt0 | oGnt0L1, 1'b0);
        chk1("reset gnt1", oGnt1 | oGnt1L1, 1'b0);
        chk1("reset ack0", oAck0 | oAck0L1, 1'b0);
        chk1("reset ack1", oAck1 | oAck1L1, 1'b0);
        chk1("reset mem en", oMemRe | oMemWe | oMemReL1 | oMemWeL1, 1'b0);
        chk32("reset addr", oMemAddr | oMemAddrL1, 32'h0);
        chk32("reset wdata", oMemWData | oMemWDataL1, 32'h0);
        chk32("reset rdata0", oRData0 | oRData0L1, 32'h0);
        chk32("reset rdata1", oRData1 | oRData1L1, 32'h0);
        iRST = 1'b0;

        for (int i = 0; i < 6; i++) begin
            runTxn(vecs[i], $sformatf("vec%0d", i));
        end

        // Both requesters held high: watch grant order and back-to-back spacing.
        resetDut();
        iReq0 = 1'b1; iReq1 = 1'b1; iWe0 = 1'b0; iWe1 = 1'b0;
        iAddr0 = 32'h300; iAddr1 = 32'h400; iMemRData = 32'h55;
        nAck = 0; gnt1Cycles = 0; overlap = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge iCLK);
            if (oGnt1) gnt1Cycles++;
            if (oGnt0 && oGnt1) overlap++;
            if (oAck0 || oAck1) begin
                if (nAck < 4) begin
                    ackAt[nAck] = c;
                    ackWho[nAck] = oAck1;
                end
                nAck++;
            end
            if (c == 16) begin
                iReq0 = 1'b0;
                iReq1 = 1'b0;
            end
        end
        chk32("tie ack count", 32'(nAck), 32'd4);
        chk32("tie gnt overlap", 32'(overlap), 32'd0);
        chk32("tie gnt1 cycles", 32'(gnt1Cycles), RrEn ? 32'd6 : 32'd0);
        for (int i = 0; i < 4 && i < nAck; i++) begin
            chk32($sformatf("tie ack%0d cycle", i), 32'(ackAt[i]), 32'(3 + 4 * i));
            chk1($sformatf("tie ack%0d owner", i), ackWho[i], RrEn & (i % 2 == 1));
        end
        @(negedge iCLK);

        // Request dropped and address changed mid-access.
        iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h500; iMemRData = 32'h77777777;
        @(posedge iCLK);
        @(negedge iCLK);
        iReq0 = 1'b0;
        iAddr0 = 32'h999;
        chk32("drop addr c1", oMemAddr, 32'h500);
        @(negedge iCLK);
        chk32("drop addr c2", oMemAddr, 32'h500);
        chk1("drop re c2", oMemRe, 1'b1);
        @(negedge iCLK);
        chk1("drop ack0", oAck0, 1'b1);
        chk32("drop rdata0", oRData0, 32'h77777777);
        @(negedge iCLK);
        chk1("drop ack0 single", oAck0, 1'b0);
        chk1("drop idle gnt0", oGnt0, 1'b0);

        // Reset during the second access cycle aborts without an acknowledge.
        iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h600; iMemRData = 32'h66666666;
        @(posedge iCLK);
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        #1;
        chk1("rst gnt0", oGnt0, 1'b0);
        chk1("rst re", oMemRe, 1'b0);
        chk32("rst addr", oMemAddr, 32'h0);
        chk32("rst rdata0", oRData0, 32'h0);
        @(negedge iCLK);
        chk1("rst no ack0", oAck0, 1'b0);
        chk1("rst no ack1", oAck1, 1'b0);
        iRST = 1'b0;
        iReq0 = 1'b0;
        mR0 = '0;
        mR1 = '0;
        v = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h700, 32'h0, 32'h0BAD0BAD,
              32'h13579BDF, 1'b1, 1'b0, 32'h700, 32'h0BAD0BAD};
        runTxn(v, "post-rst");

        // Single-cycle memory window on the MEM_LAT=1 instance.
        resetDut();
        iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h40; iMemRData = 32'hA1B2C3D4;
        @(posedge iCLK);
        @(negedge iCLK);
        chk1("lat1 re c1", oMemReL1, 1'b1);
        chk1("lat1 gnt0 c1", oGnt0L1, 1'b1);
        chk32("lat1 addr c1", oMemAddrL1, 32'h40);
        chk1("lat1 ack0 c1", oAck0L1, 1'b0);
        @(negedge iCLK);
        iReq0 = 1'b0;
        chk1("lat1 ack0 c2", oAck0L1, 1'b1);
        chk1("lat1 re c2", oMemReL1, 1'b0);
        chk32("lat1 rdata0", oRData0L1, 32'hA1B2C3D4);
        @(negedge iCLK);
        chk1("lat1 ack0 c3", oAck0L1, 1'b0);
        chk1("lat1 gnt0 c3", oGnt0L1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
